// File: rtl/mux_two_to_one.sv
// Registered 2:1 multiplexer with valid qualifier. REG_OUT selects one register
// stage (1-cycle latency) or a purely combinational path.
module mux_two_to_one #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sel_val;

  assign w_sel_val = select ? b : a;

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] r_out;
      logic             r_out_valid;

      // Data captures every cycle; only the valid bit tracks in_valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out       <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out       <= w_sel_val;
          r_out_valid <= in_valid;
        end
      end

      assign out       = r_out;
      assign out_valid = r_out_valid;
    end else begin : g_comb
      // Reset only suppresses the qualifier; the data path stays transparent.
      assign out       = w_sel_val;
      assign out_valid = in_valid & rst_n;
    end
  endgenerate

endmodule

// File: tb/tb_mux_two_to_one.sv
// Directed bench for mux_two_to_one: 1-bit and 8-bit registered instances plus
// an 8-bit combinational instance.
module tb_mux_two_to_one;

  logic       clk;
  logic       rst_n;
  logic       rst_n_c;

  logic       a1, b1, sel1, iv1;
  logic       out1, ov1;

  logic [7:0] a8, b8;
  logic       sel8, iv8;
  logic [7:0] out8;
  logic       ov8;

  logic [7:0] ac, bc;
  logic       selc, ivc;
  logic [7:0] outc;
  logic       ovc;

  int errors = 0;
  int checks = 0;

  logic [7:0] tt_exp;
  logic [2:0] vec;

  mux_two_to_one #(.WIDTH(1), .REG_OUT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .select(sel1),
    .in_valid(iv1), .out(out1), .out_valid(ov1)
  );

  mux_two_to_one #(.WIDTH(8), .REG_OUT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .select(sel8),
    .in_valid(iv8), .out(out8), .out_valid(ov8)
  );

  mux_two_to_one #(.WIDTH(8), .REG_OUT(0)) u_comb (
    .clk(clk), .rst_n(rst_n_c), .a(ac), .b(bc), .select(selc),
    .in_valid(ivc), .out(outc), .out_valid(ovc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst_n_c = 1'b1;
    a1 = 1'b1; b1 = 1'b1; sel1 = 1'b1; iv1 = 1'b1;
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b1; iv8 = 1'b1;
    ac = 8'h00; bc = 8'h00; selc = 1'b0; ivc = 1'b1;
    #1;
    check("rst_out_t0", {7'd0, out1}, 8'h00);
    check("rst_ov_t0", {7'd0, ov1}, 8'h00);

    // Reset held through clock edges with nonzero inputs.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out1", {7'd0, out1}, 8'h00);
      check("rst_ov1", {7'd0, ov1}, 8'h00);
      check("rst_out8", out8, 8'h00);
      check("rst_ov8", {7'd0, ov8}, 8'h00);
    end

    rst_n = 1'b1;
    #1;
    check("rel_pre_edge", {7'd0, out1}, 8'h00);
    tick();
    check("rel_out1", {7'd0, out1}, 8'h01);
    check("rel_ov1", {7'd0, ov1}, 8'h01);
    check("rel_out8", out8, 8'h3C);

    // Truth table, vec = {sel,a,b}: expected outputs 0,0,1,1,0,1,0,1.
    tt_exp = 8'hAC;
    for (int i = 0; i < 8; i++) begin
      vec  = 3'(i);
      sel1 = vec[2]; a1 = vec[1]; b1 = vec[0]; iv1 = 1'b1;
      #2;
      if (i == 1) check("tt_latency", {7'd0, out1}, {7'd0, tt_exp[0]});
      tick();
      check($sformatf("tt_%0d%0d%0d", vec[2], vec[1], vec[0]), {7'd0, out1}, {7'd0, tt_exp[i]});
      check("tt_ov", {7'd0, ov1}, 8'h01);
    end

    // Wide path: select 0,1,0 with in_valid 1,0,1.
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0; iv8 = 1'b1;
    tick();
    check("wide0_out", out8, 8'hA5);
    check("wide0_ov", {7'd0, ov8}, 8'h01);
    sel8 = 1'b1; iv8 = 1'b0;
    tick();
    check("wide1_out", out8, 8'h3C);
    check("wide1_ov", {7'd0, ov8}, 8'h00);
    sel8 = 1'b0; iv8 = 1'b1;
    tick();
    check("wide2_out", out8, 8'hA5);
    check("wide2_ov", {7'd0, ov8}, 8'h01);

    // a==b: output independent of select.
    a8 = 8'h5A; b8 = 8'h5A; sel8 = 1'b1;
    tick();
    check("aeqb_sel1", out8, 8'h5A);
    sel8 = 1'b0;
    tick();
    check("aeqb_sel0", out8, 8'h5A);

    // Asynchronous reset mid-stream while out=3C.
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b1; iv8 = 1'b1;
    tick();
    check("mid_pre_out", out8, 8'h3C);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", out8, 8'h00);
    check("mid_rst_ov", {7'd0, ov8}, 8'h00);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_hold_out", out8, 8'h00);
    tick();
    check("mid_resume_out", out8, 8'h3C);
    check("mid_resume_ov", {7'd0, ov8}, 8'h01);

    // Combinational instance: zero-delay tracking between edges.
    ac = 8'h12; bc = 8'h34; selc = 1'b0; ivc = 1'b1;
    #1;
    check("comb_a", outc, 8'h12);
    check("comb_ov", {7'd0, ovc}, 8'h01);
    selc = 1'b1;
    #1;
    check("comb_b", outc, 8'h34);
    bc = 8'hC7;
    #1;
    check("comb_b_chg", outc, 8'hC7);
    ivc = 1'b0;
    #1;
    check("comb_ov_low", {7'd0, ovc}, 8'h00);
    ivc = 1'b1; rst_n_c = 1'b0;
    #1;
    check("comb_rst_out", outc, 8'hC7);
    check("comb_rst_ov", {7'd0, ovc}, 8'h00);
    selc = 1'b0;
    #1;
    check("comb_rst_sel", outc, 8'h12);
    rst_n_c = 1'b1;
    #1;
    check("comb_rel_ov", {7'd0, ovc}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_two_to_one.md
Name: mux_two_to_one

Overview:
- Registered 2:1 multiplexer: selects operand `a` (select=0) or operand `b` (select=1).
- Presents the result one clock later with a valid qualifier.
- Used as a generic datapath steering element wherever two sources feed one sink.
- Width and output registering are parameterised so the same block serves 1-bit control steering and wide data buses.

Parameters:
- WIDTH, 1, bit width of a, b and out.
- REG_OUT, 1, 1 = output registered (1-cycle latency); 0 = purely combinational out (out_valid follows in_valid combinationally).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand routed when select=0.
- b  input  WIDTH  operand routed when select=1.
- select  input  1  0 -> a, 1 -> b.
- in_valid  input  1  qualifies a/b/select this cycle; tie high for free-running use.
- out  output  WIDTH  selected operand.
- out_valid  output  1  out carries a valid selection.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Selection function: sel_val = select ? b : a, bitwise across all WIDTH bits. No arithmetic and no width conversion.
- REG_OUT=1 (default):
  - On each rising clk edge with rst_n=1: out <= sel_val and out_valid <= in_valid.
  - out updates every cycle regardless of in_valid (free-running data path).
  - out_valid marks meaningful cycles.
  - Latency is exactly 1 cycle, throughput 1 per cycle, no back-pressure.
- REG_OUT=0:
  - out = sel_val and out_valid = in_valid, purely combinational.
  - rst_n has no effect on out, but forces out_valid=0 while asserted.
- Reset:
  - While rst_n=0: out = 0 (all WIDTH bits) and out_valid = 0, immediately and without waiting for clk.
  - Deassertion is synchronised by the integrator upstream.
  - The first capture occurs on the first rising edge with rst_n=1.
- Reset mid-operation: asserting rst_n low between edges clears out and out_valid at once. Any pending value is discarded, with no partial update.
- Simultaneous change of select and operands: the value captured at the edge is sel_val from the inputs present at that edge. No glitch is propagated to out when REG_OUT=1.
- select switching every cycle: out follows with 1-cycle lag and no dead cycle.
- a==b: out equals that value independent of select.
- Inputs must be 0/1 only; X/Z on select is unsupported and must not be driven by upstream logic.

Decomposition:
- No shared package is needed; WIDTH is the only configurable quantity and stays a module parameter.
- No sub-module: the selection is one conditional assignment feeding one register stage.

Test Plan:
- Reset: hold rst_n=0 with a=1, b=1, select=1, toggling clk -> out=0 and out_valid=0 throughout. Release -> out=1 one edge later.
- Exhaustive truth table, WIDTH=1, in_valid=1, 10 ns per vector: (sel,a,b) = 000,001,010,011,100,101,110,111 -> out one cycle later = 0,0,1,1,0,1,0,1.
- Wide path, WIDTH=8: a=8'hA5, b=8'h3C, select toggling 0,1,0 on consecutive cycles -> out = A5,3C,A5 with 1-cycle lag. in_valid pulsed 1,0,1 -> out_valid = 1,0,1 lagged one cycle.
- Asynchronous reset mid-stream: while out=8'h3C, drop rst_n between edges -> out=0 and out_valid=0 before the next edge. Restore -> resumes with the current inputs on the next edge.
- REG_OUT=0: vary select, a and b between clock edges -> out tracks select?b:a with zero delay. rst_n=0 forces out_valid=0 only.
